// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: instruction decode, 32x32 register file with
// write-through bypass, and the registered EX-side operand/control bundle.
module id_ex_stage #(
    parameter int unsigned RF_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [1:0]  Alu_op,
    output logic [5:0]  funct,
    output logic [4:0]  dest,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        valid_out
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned IMM_W = 16;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0]      FN_ADD   = 6'b100000;
    localparam logic [5:0]      FN_SUB   = 6'b100010;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [1:0]      alu_op;
        logic [5:0]      funct;
        logic [RA_W-1:0] dest;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            valid;
    } ex_t;

    logic [XLEN-1:0] rf [RF_DEPTH];

    logic [OP_W-1:0] opcode_c;
    logic [RA_W-1:0] rs_c;
    logic [RA_W-1:0] rt_c;
    logic [XLEN-1:0] sext_c;
    logic [XLEN-1:0] rs_val_c;
    logic [XLEN-1:0] rt_val_c;
    ex_t             dec_c;
    ex_t             ex_q;

    assign opcode_c = instr[31:26];
    assign rs_c     = instr[25:21];
    assign rt_c     = instr[20:16];
    assign sext_c   = {{(XLEN-IMM_W){instr[15]}}, instr[15:0]};

    // Operand read; a same-cycle write-back to a source register wins over the array.
    always_comb begin : operand_read
        rs_val_c = rf[rs_c];
        rt_val_c = rf[rt_c];
        if (wb_en && (wb_addr != '0) && (wb_addr == rs_c)) rs_val_c = wb_data;
        if (wb_en && (wb_addr != '0) && (wb_addr == rt_c)) rt_val_c = wb_data;
    end

    // Decode; unknown opcodes and invalid slots fall through as an all-zero bubble.
    always_comb begin : decode
        dec_c = '0;
        if (instr_valid) begin
            case (opcode_c)
                OP_RTYPE: begin
                    dec_c.a         = rs_val_c;
                    dec_c.b         = rt_val_c;
                    dec_c.alu_op    = 2'b10;
                    dec_c.funct     = instr[5:0];
                    dec_c.dest      = instr[15:11];
                    dec_c.reg_write = 1'b1;
                    dec_c.valid     = 1'b1;
                end
                OP_LW, OP_SW: begin
                    dec_c.a         = rs_val_c;
                    dec_c.b         = sext_c;
                    dec_c.alu_op    = 2'b00;
                    dec_c.funct     = FN_ADD;
                    dec_c.dest      = rt_c;
                    dec_c.reg_write = (opcode_c == OP_LW);
                    dec_c.mem_read  = (opcode_c == OP_LW);
                    dec_c.mem_write = (opcode_c == OP_SW);
                    dec_c.valid     = 1'b1;
                end
                OP_BEQ: begin
                    dec_c.a      = rs_val_c;
                    dec_c.b      = rt_val_c;
                    dec_c.alu_op = 2'b01;
                    dec_c.funct  = FN_SUB;
                    dec_c.branch = 1'b1;
                    dec_c.valid  = 1'b1;
                end
                OP_ADDI: begin
                    dec_c.a         = rs_val_c;
                    dec_c.b         = sext_c;
                    dec_c.alu_op    = 2'b00;
                    dec_c.funct     = FN_ADD;
                    dec_c.dest      = rt_c;
                    dec_c.reg_write = 1'b1;
                    dec_c.valid     = 1'b1;
                end
                default: dec_c = '0;
            endcase
        end
    end

    // EX register: flush beats stall; stall holds the previous bundle.
    always_ff @(posedge clk or negedge rst_n) begin : ex_reg
        if (!rst_n) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (!stall) begin
            ex_q <= dec_c;
        end
    end

    // Register file; location 0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin : reg_file
        if (!rst_n) begin
            for (int i = 0; i < int'(RF_DEPTH); i++) rf[i] <= '0;
        end else if (wb_en && (wb_addr != '0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    assign a         = ex_q.a;
    assign b         = ex_q.b;
    assign Alu_op    = ex_q.alu_op;
    assign funct     = ex_q.funct;
    assign dest      = ex_q.dest;
    assign reg_write = ex_q.reg_write;
    assign mem_read  = ex_q.mem_read;
    assign mem_write = ex_q.mem_write;
    assign branch    = ex_q.branch;
    assign valid_out = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: architectural model compared every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] a, b;
    logic [1:0]  Alu_op;
    logic [5:0]  funct;
    logic [4:0]  dest;
    logic        reg_write, mem_read, mem_write, branch, valid_out;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.RF_DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .a(a), .b(b), .Alu_op(Alu_op), .funct(funct),
        .dest(dest), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        v;
    } exp_t;

    // Architectural model: register contents as a plain array, EX bundle as a value.
    logic [31:0] m_rf [32];
    exp_t        m_exp;

    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] ra,
                                          input logic [31:0] rb);
        exp_t e;
        logic [31:0] se;
        e  = '0;
        se = 32'($signed(ins[15:0]));
        case (ins[31:26])
            6'd0:  begin e.a = ra; e.b = rb; e.op = 2'd2; e.fn = ins[5:0];
                         e.dest = ins[15:11]; e.rw = 1'b1; e.v = 1'b1; end
            6'd35: begin e.a = ra; e.b = se; e.fn = 6'd32; e.dest = ins[20:16];
                         e.rw = 1'b1; e.mr = 1'b1; e.v = 1'b1; end
            6'd43: begin e.a = ra; e.b = se; e.fn = 6'd32; e.dest = ins[20:16];
                         e.mw = 1'b1; e.v = 1'b1; end
            6'd4:  begin e.a = ra; e.b = rb; e.op = 2'd1; e.fn = 6'd34;
                         e.br = 1'b1; e.v = 1'b1; end
            6'd8:  begin e.a = ra; e.b = se; e.fn = 6'd32; e.dest = ins[20:16];
                         e.rw = 1'b1; e.v = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // The write-back of an edge is applied first, so operands see the newest value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
            m_exp = '0;
        end else begin
            if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
            if (flush)
                m_exp = '0;
            else if (!stall)
                m_exp = instr_valid ? model_decode(instr, m_rf[instr[25:21]], m_rf[instr[20:16]])
                                    : '0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            exp_t got;
            got = {a, b, Alu_op, funct, dest, reg_write, mem_read, mem_write, branch, valid_out};
            n_tests++;
            if (got !== m_exp) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, got, m_exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs and return at the following falling edge.
    task automatic cyc(input logic [31:0] ins, input logic iv, input logic st, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
        instr = ins; instr_valid = iv; stall = st; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(valid_out), 32'd0);
        chk("reset_a", a, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        cyc('0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd25);
        cyc('0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd23);
        cyc(rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("add_a", a, 32'd25);
        chk("add_b", b, 32'd23);
        chk("add_aluop", 32'(Alu_op), 32'd2);
        chk("add_funct", 32'(funct), 32'h20);
        chk("add_dest", 32'(dest), 32'd3);
        chk("add_ctl", {27'd0, reg_write, mem_read, mem_write, branch, valid_out}, 32'b10001);

        cyc('0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd57);
        cyc(itype(6'h23, 5'd1, 5'd5, 16'hFFFC), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lw_a", a, 32'd57);
        chk("lw_b", b, 32'hFFFF_FFFC);
        chk("lw_ctl", {22'd0, Alu_op, dest, reg_write, mem_read, mem_write}, {22'd0, 2'd0, 5'd5, 3'b110});

        cyc(itype(6'h04, 5'd4, 5'd4, 16'h0010), 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'd35);
        chk("beq_a_bypass", a, 32'd35);
        chk("beq_b_bypass", b, 32'd35);
        chk("beq_ctl", {23'd0, Alu_op, funct, branch}, {23'd0, 2'd1, 6'h22, 1'b1});
        chk("beq_rw", 32'(reg_write), 32'd0);

        cyc('0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd99);
        cyc(rtype(5'd0, 5'd1, 5'd7, 6'h20), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("r0_reads_zero", a, 32'd0);

        cyc(itype(6'h2B, 5'd2, 5'd9, 16'h0008), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("sw_ctl", {27'd0, reg_write, mem_read, mem_write, branch, valid_out}, 32'b00101);
        cyc(itype(6'h08, 5'd1, 5'd6, 16'h8000), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("addi_b_sext", b, 32'hFFFF_8000);
        cyc(itype(6'h3F, 5'd1, 5'd6, 16'h1234), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("unknown_op_bubble", 32'(valid_out), 32'd0);
        chk("unknown_op_a", a, 32'd0);

        cyc(rtype(5'd1, 5'd2, 5'd3, 6'h22), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        cyc(rtype(5'd2, 5'd2, 5'd8, 6'h20), 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'd77);
        cyc(itype(6'h23, 5'd2, 5'd9, 16'h0004), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cyc('0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("stall_hold_a", a, 32'd57);
        chk("stall_hold_b", b, 32'd23);
        chk("stall_hold_funct", 32'(funct), 32'h22);
        chk("stall_hold_valid", 32'(valid_out), 32'd1);
        cyc(rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("flush_over_stall", 32'(valid_out), 32'd0);
        cyc(rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("invalid_bubble", 32'(valid_out), 32'd0);
        cyc(rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("reissue_after_stall", a, 32'd77);

        cyc(rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        instr = '0; instr_valid = 1'b0; stall = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(valid_out), 32'd0);
        chk("async_rst_a", a, 32'd0);
        chk("async_rst_ctl", {19'd0, b[7:0], Alu_op, reg_write, branch, dest[0]}, 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cyc(rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("r1_after_reset", a, 32'd0);
        chk("valid_after_reset", 32'(valid_out), 32'd1);

        cyc('0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have the parameter RF_DEPTH, default 32, giving the number of 32-bit general registers; it is fixed at 32.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have the port instr, input, 32 bits: the decoded-stage instruction word.
REQ-005 The block SHALL have the port instr_valid, input, 1 bit: instr holds a real instruction.
REQ-006 The block SHALL have the port stall, input, 1 bit: hold the EX-side outputs.
REQ-007 The block SHALL have the port flush, input, 1 bit: replace the next EX entry with a bubble.
REQ-008 The block SHALL have the ports wb_en (1), wb_addr (5) and wb_data (32), all inputs, forming the register write-back port.
REQ-009 The block SHALL have the outputs a and b, 32 bits each: the registered ALU operands.
REQ-010 The block SHALL have the outputs Alu_op (2) and funct (6): the registered ALU control.
REQ-011 The block SHALL have the outputs dest (5), reg_write, mem_read, mem_write, branch and valid_out (1 bit each): the registered downstream control.

Function
REQ-012 Decode SHALL use opcode instr[31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0] and funct [5:0].
REQ-013 Decode of R-type (000000) SHALL give a=R[rs], b=R[rt], Alu_op=2'b10, funct=instr funct, dest=rd, reg_write=1.
REQ-014 Decode of lw (100011) SHALL give a=R[rs], b=sext(imm), Alu_op=00, funct=6'b100000, dest=rt, reg_write=1, mem_read=1.
REQ-015 Decode of sw (101011) SHALL match lw, but with mem_write=1, reg_write=0, and dest=rt with dest don't-care downstream.
REQ-016 Decode of beq (000100) SHALL give a=R[rs], b=R[rt], Alu_op=01, funct=6'b100010, branch=1, reg_write=0.
REQ-017 Decode of addi (001000) SHALL give a=R[rs], b=sext(imm), Alu_op=00, funct=6'b100000, dest=rt, reg_write=1.
REQ-018 Any other opcode SHALL be a bubble: valid_out=0, all control 0, a=b=0, Alu_op=00, funct=0, dest=0.
REQ-019 Sign extension SHALL replicate imm[15] into bits 31:16.
REQ-020 Latency SHALL be 1 cycle: the decode of instr at edge N appears on the outputs after edge N.
REQ-021 When instr_valid=0 and neither stall nor flush is active, the next output SHALL be a bubble (REQ-018).
REQ-022 Stall: while stall=1 and flush=0, all EX-side outputs SHALL hold their values.
REQ-023 Flush: flush=1 SHALL load a bubble at the next edge, regardless of stall; flush has priority over stall.
REQ-024 The register file SHALL be 32x32 and written at the rising edge when wb_en=1 and wb_addr!=0.
REQ-025 Register-file writes SHALL proceed during stall and flush.
REQ-026 R[0] SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-027 Write-through bypass: if wb_en=1 and wb_addr equals rs (or rt), nonzero, in the same cycle, the operand SHALL take wb_data instead of the stale array value.
REQ-028 A stall held across a write-back to a source register SHALL NOT update the held a/b; the producer re-supplies the instruction after the stall.

Reset
REQ-029 When rst_n=0, all 32 registers SHALL clear to 0 immediately (asynchronously).
REQ-030 When rst_n=0, a, b, Alu_op, funct, dest and all control outputs SHALL clear to 0, including valid_out=0.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override both.
REQ-032 The first edge after rst_n rises SHALL behave normally.

Verification
REQ-033 The bench SHALL cover: after reset, wb write R1=25 and R2=23, then R-type add rs=1, rt=2, rd=3 -> next cycle a=25, b=23, Alu_op=10, funct=100000, dest=3, reg_write=1, valid_out=1.
REQ-034 The bench SHALL cover: lw rs=1, imm=16'hFFFC with R1=57 -> a=57, b=32'hFFFFFFFC, Alu_op=00, mem_read=1, dest=rt.
REQ-035 The bench SHALL cover: beq rs=4, rt=4, with wb writing R4=35 in the same cycle -> a=35, b=35 via bypass, Alu_op=01, funct=100010, branch=1.
REQ-036 The bench SHALL cover: wb_addr=0, wb_data=99, then R-type reading rs=0 -> a=0.
REQ-037 The bench SHALL cover: stall high for 3 cycles with a new instr each cycle -> outputs unchanged; flush together with stall -> valid_out=0 next cycle.
REQ-038 The bench SHALL cover: rst_n pulsed low between edges while valid_out=1 -> all outputs 0 immediately, and R1 then reads 0.
